// File: rtl/pipelined_adder_sub.sv
// Pipelined ripple-carry adder/subtractor with a global-stall valid/ready handshake.
// The WIDTH-bit carry chain is cut into STAGES slices, one register stage per slice.
module pipelined_adder_sub #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   // Per-stage registers: operands travel with the beat, sum fills in slice by slice.
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] opb_q   [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic             carry_q [STAGES];
   logic             valid_q [STAGES];

   logic [WIDTH-1:0] a_d     [STAGES];
   logic [WIDTH-1:0] opb_d   [STAGES];
   logic [WIDTH-1:0] sum_d   [STAGES];
   logic             carry_d [STAGES];
   logic             valid_d [STAGES];

   // What each stage sees at its input: the port side for stage 0, the previous register otherwise.
   logic [WIDTH-1:0] src_a   [STAGES];
   logic [WIDTH-1:0] src_opb [STAGES];
   logic [WIDTH-1:0] src_sum [STAGES];
   logic             src_c   [STAGES];
   logic             src_v   [STAGES];

   logic advance;

   assign out_valid = valid_q[LAST];
   assign advance   = out_ready || !out_valid;
   // Reset empties the pipe, so accepting is always safe while it is asserted.
   assign in_ready  = advance || rst;

   always_comb begin
      src_a[0]   = a;
      src_opb[0] = sub ? ~b : b;
      src_c[0]   = sub | cin;
      src_sum[0] = '0;
      src_v[0]   = in_valid;
      for (int k = 1; k < STAGES; k++) begin
         src_a[k]   = a_q[k-1];
         src_opb[k] = opb_q[k-1];
         src_c[k]   = carry_q[k-1];
         src_sum[k] = sum_q[k-1];
         src_v[k]   = valid_q[k-1];
      end
   end

   // Each stage ripples only its own CHUNK bits, keeping the critical path to one slice.
   always_comb begin
      logic c;
      for (int k = 0; k < STAGES; k++) begin
         // NOTE: blocking assignments here model combinational ripple; every output gets a value
         // before any conditional use, so no latch is inferred.
         c          = src_c[k];
         sum_d[k]   = src_sum[k];
         a_d[k]     = src_a[k];
         opb_d[k]   = src_opb[k];
         valid_d[k] = src_v[k];
         for (int i = 0; i < CHUNK; i++) begin
            sum_d[k][k*CHUNK+i] = src_a[k][k*CHUNK+i] ^ src_opb[k][k*CHUNK+i] ^ c;
            c = (src_a[k][k*CHUNK+i] & src_opb[k][k*CHUNK+i]) |
                (c & (src_a[k][k*CHUNK+i] ^ src_opb[k][k*CHUNK+i]));
         end
         carry_d[k] = c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            // NOTE: data is cleared too, so sum/cout/ovf read as zero right after reset.
            valid_q[k] <= 1'b0;
            a_q[k]     <= '0;
            opb_q[k]   <= '0;
            sum_q[k]   <= '0;
            carry_q[k] <= 1'b0;
         end
      end else if (advance) begin
         for (int k = 0; k < STAGES; k++) begin
            // NOTE: non-blocking so every stage shifts from the pre-edge value of its neighbour.
            valid_q[k] <= valid_d[k];
            a_q[k]     <= a_d[k];
            opb_q[k]   <= opb_d[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
         end
      end
   end

   assign sum  = sum_q[LAST];
   assign cout = carry_q[LAST];
   // Signed overflow: like-signed effective operands producing a result of the other sign.
   assign ovf  = (a_q[LAST][WIDTH-1] == opb_q[LAST][WIDTH-1]) &&
                 (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Bench for pipelined_adder_sub: three instances (STAGES=4, 1, 16) share stimulus;
// a queue-based arithmetic model per instance is checked on every output transfer.
module tb_pipelined_adder_sub;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [W-1:0]  a_r, b_r;
   logic          cin_r, sub_r;
   logic          out_ready;

   logic          ir_w  [3];
   logic          ov_w  [3];
   logic [W-1:0]  sum_w [3];
   logic          co_w  [3];
   logic          of_w  [3];

   int n_checks = 0;
   int n_pass   = 0;

   logic [W+1:0] exp_q [3][$];
   logic         held_v [3];
   logic [W+1:0] held_d [3];

   always #5 clk = ~clk;

   pipelined_adder_sub #(.WIDTH(W), .STAGES(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[0]),
      .a(a_r), .b(b_r), .cin(cin_r), .sub(sub_r),
      .out_valid(ov_w[0]), .out_ready(out_ready),
      .sum(sum_w[0]), .cout(co_w[0]), .ovf(of_w[0]));

   pipelined_adder_sub #(.WIDTH(W), .STAGES(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[1]),
      .a(a_r), .b(b_r), .cin(cin_r), .sub(sub_r),
      .out_valid(ov_w[1]), .out_ready(out_ready),
      .sum(sum_w[1]), .cout(co_w[1]), .ovf(of_w[1]));

   pipelined_adder_sub #(.WIDTH(W), .STAGES(16)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_w[2]),
      .a(a_r), .b(b_r), .cin(cin_r), .sub(sub_r),
      .out_valid(ov_w[2]), .out_ready(out_ready),
      .sum(sum_w[2]), .cout(co_w[2]), .ovf(of_w[2]));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Reference arithmetic: plain integer sum, then the signed-overflow rule on the effective operands.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic s);
      logic [W-1:0] eff_b;
      logic [W:0]   r;
      logic         v;
      eff_b = s ? ~y : y;
      r     = {1'b0, x} + {1'b0, eff_b} + (W+1)'(s ? 1'b1 : c);
      v     = (x[W-1] == eff_b[W-1]) && (r[W-1] != x[W-1]);
      return {v, r};
   endfunction

   // Scoreboard: values at the falling edge are what the next rising edge will act on.
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         check($sformatf("in_ready[%0d]", d), 32'(ir_w[d]), 32'(rst || out_ready || !ov_w[d]));
         if (rst) begin
            exp_q[d].delete();
            held_v[d] = 1'b0;
         end else begin
            if (held_v[d]) begin
               check($sformatf("stall_valid[%0d]", d), 32'(ov_w[d]), 32'd1);
               check($sformatf("stall_data[%0d]", d), 32'({of_w[d], co_w[d], sum_w[d]}),
                     32'(held_d[d]));
            end
            held_v[d] = ov_w[d] && !out_ready;
            held_d[d] = {of_w[d], co_w[d], sum_w[d]};
            if (ov_w[d] && out_ready) begin
               if (exp_q[d].size() == 0) begin
                  check($sformatf("unexpected_out[%0d]", d), 32'(sum_w[d]), 32'hdead_beef);
               end else begin
                  check($sformatf("result[%0d]", d), 32'({of_w[d], co_w[d], sum_w[d]}),
                        32'(exp_q[d].pop_front()));
               end
            end
            if (in_valid && ir_w[d]) exp_q[d].push_back(model(a_r, b_r, cin_r, sub_r));
         end
      end
   end

   // Present one beat and hold it until the STAGES=4 instance accepts it.
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
      bit ok = 1'b0;
      in_valid = 1'b1; a_r = x; b_r = y; cin_r = c; sub_r = s;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (ir_w[0]) begin ok = 1'b1; break; end
      end
      if (!ok) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // One beat through an idle pipe, with exact latency and literal result on every instance.
   task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                           input logic s, input logic [W-1:0] es, input logic ec, input logic eo);
      string tag;
      tag = $sformatf("%0h%s%0h", x, s ? "-" : "+", y);
      out_ready = 1'b1;
      send(x, y, c, s);
      check({"s1_valid ", tag}, 32'(ov_w[1]), 32'd1);
      check({"s1_data ", tag}, 32'({of_w[1], co_w[1], sum_w[1]}), 32'({eo, ec, es}));
      @(posedge clk); @(posedge clk); #1;
      check({"s4_early ", tag}, 32'(ov_w[0]), 32'd0);
      @(posedge clk); #1;
      check({"s4_valid ", tag}, 32'(ov_w[0]), 32'd1);
      check({"s4_data ", tag}, 32'({of_w[0], co_w[0], sum_w[0]}), 32'({eo, ec, es}));
      repeat (11) @(posedge clk);
      #1;
      check({"s16_early ", tag}, 32'(ov_w[2]), 32'd0);
      @(posedge clk); #1;
      check({"s16_valid ", tag}, 32'(ov_w[2]), 32'd1);
      check({"s16_data ", tag}, 32'({of_w[2], co_w[2], sum_w[2]}), 32'({eo, ec, es}));
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("%s_valid[%0d]", tag, d), 32'(ov_w[d]), 32'd0);
         check($sformatf("%s_out[%0d]", tag, d), 32'({of_w[d], co_w[d], sum_w[d]}), 32'd0);
         check($sformatf("%s_ready[%0d]", tag, d), 32'(ir_w[d]), 32'd1);
      end
   endtask

   initial begin
      int acc;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a_r = '0; b_r = '0; cin_r = 1'b0; sub_r = 1'b0;
      for (int d = 0; d < 3; d++) held_v[d] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      directed(16'h1234, 16'h0001, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0);
      directed(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      directed(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      directed(16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
      directed(16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1);

      // Fill the 4-stage pipe with the output blocked, then release.
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) send(16'(i), 16'h0100, 1'b0, 1'b0);
      check("full_ready", 32'(ir_w[0]), 32'd0);
      check("full_valid", 32'(ov_w[0]), 32'd1);
      check("full_sum", 32'(sum_w[0]), 32'h0101);
      repeat (3) @(posedge clk);
      #1;
      check("held_sum", 32'(sum_w[0]), 32'h0101);
      check("held_ready", 32'(ir_w[0]), 32'd0);
      out_ready = 1'b1;
      for (int j = 2; j <= 4; j++) begin
         @(posedge clk); #1;
         check($sformatf("release_valid%0d", j), 32'(ov_w[0]), 32'd1);
         check($sformatf("release_sum%0d", j), 32'(sum_w[0]), 32'h0100 + 32'(j));
      end
      repeat (20) @(posedge clk);
      #1;

      // Random streaming with random back-pressure.
      acc = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         if (in_valid && ir_w[0]) acc++;
         @(posedge clk); #1;
         if (acc >= 100) break;
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         a_r       = 16'($urandom);
         b_r       = 16'($urandom);
         cin_r     = 1'($urandom_range(0, 1));
         sub_r     = 1'($urandom_range(0, 1));
      end
      check("random_accepts", 32'(acc >= 100), 32'd1);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) check($sformatf("drained[%0d]", d), 32'(exp_q[d].size()), 32'd0);

      // Reset with beats in flight: nothing stale may appear afterwards.
      for (int i = 0; i < 3; i++) send(16'h1000 + 16'(i), 16'h0011, 1'b0, 1'b0);
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) check($sformatf("ready_in_rst[%0d]", d), 32'(ir_w[d]), 32'd1);
      @(posedge clk); #1;
      check_reset_state("midrst");
      rst = 1'b0; out_ready = 1'b1;
      for (int t = 0; t < 25; t++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++)
            if (ov_w[d]) check($sformatf("stale[%0d]", d), 32'(ov_w[d]), 32'd0);
      end
      check("post_rst_idle", 32'(ov_w[0] | ov_w[1] | ov_w[2]), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
